gray_bin_decoder: RTL and testbench



---
 rtl/gray_pkg.sv | 43 ++++
 rtl/gray2bin_comb.sv | 19 +
 rtl/gray_bin_decoder.sv | 142 ++++++++++++++
 tb/tb_gray_bin_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
//
// Contents:
//   GRAY_W        default Gray/binary word width
//   POP_IN_W      widest vector popcount accepts
//   POP_OUT_W     width of the popcount result
//   gray_t/bin_t  default-width word typedefs
//   ctrl_state_e  EMPTY/FULL occupancy of the decoder output register
//   gray2bin      Gray-to-binary conversion of a default-width word
//   popcount      number of set bits in a vector of up to POP_IN_W bits
package gray_pkg;

  localparam int GRAY_W    = 3;
  localparam int POP_IN_W  = 32;
  localparam int POP_OUT_W = 6;

  typedef logic [GRAY_W-1:0] gray_t;
  typedef logic [GRAY_W-1:0] bin_t;

  typedef enum logic {
    CTRL_EMPTY = 1'b0,
    CTRL_FULL  = 1'b1
  } ctrl_state_e;

  function automatic bin_t gray2bin(input gray_t g);
    bin_t b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      n = n + POP_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary decoder, WIDTH-parameterised and reusable.
//
// Ports:
//   gray  in   WIDTH  Gray-coded word, MSB = bit WIDTH-1
//   bin   out  WIDTH  binary equivalent
module gray2bin_comb #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it; writing it
  // as a reduction keeps the decode free of a bit-to-bit feedback chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_bin_decoder.sv
// Registered, valid/ready-handshaked Gray-to-binary decoder with an optional
// adjacency checker that flags and counts multi-bit jumps between
// consecutive accepted Gray words.
//
// Build option:
//   GRAY_STEP_CHECK_EN  when defined, the step checker, previous-word
//                       register, first-word flag and saturating error
//                       counter are built; otherwise out_step_err and
//                       err_cnt are tied to zero.
//
// Ports:
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous active-low reset
//   in_valid      in   1          upstream offers in_gray
//   in_ready      out  1          decoder can accept this cycle
//   in_gray       in   WIDTH      Gray-coded input word
//   out_valid     out  1          out_bin holds a decoded word
//   out_ready     in   1          downstream takes out_bin this cycle
//   out_bin       out  WIDTH      decoded binary word
//   out_step_err  out  1          word is not Gray-adjacent to the previous one
//   err_cnt       out  ERR_CNT_W  saturating step-error count since reset
module gray_bin_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ctrl_state_e      state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;

  gray2bin_comb #(.WIDTH(WIDTH)) u_decode (
    .gray (in_gray),
    .bin  (dec_bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTRL_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // An accept while full replaces the word in place, so the register only
  // empties when downstream takes the word and nothing new arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_EMPTY: if (accept) state_d = CTRL_FULL;
      CTRL_FULL:  if (!accept && out_ready) state_d = CTRL_EMPTY;
      default:    state_d = CTRL_EMPTY;
    endcase
  end

  // in_ready passes out_ready straight through when full; there is no skid
  // buffer, so a full register can only take a word as the old one leaves.
  always_comb begin
    out_valid = (state_q == CTRL_FULL);
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    out_bin_d = out_bin_q;
    if (accept) begin
      out_bin_d = dec_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bin_q <= '0;
    end else begin
      out_bin_q <= out_bin_d;
    end
  end

  assign out_bin = out_bin_q;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
  logic                 first_flag_q, first_flag_d;
  logic                 out_step_err_q, out_step_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [POP_OUT_W-1:0] step_dist;
  logic                 step_err;

  // A repeated word (distance 0) is legal; the very first word after reset
  // has nothing to compare against and is never an error.
  always_comb begin
    step_dist      = popcount(POP_IN_W'(in_gray ^ prev_gray_q));
    step_err       = !first_flag_q && (step_dist >= POP_OUT_W'(2));
    prev_gray_d    = prev_gray_q;
    first_flag_d   = first_flag_q;
    out_step_err_d = out_step_err_q;
    err_cnt_d      = err_cnt_q;
    if (accept) begin
      prev_gray_d    = in_gray;
      first_flag_d   = 1'b0;
      out_step_err_d = step_err;
      if (step_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q    <= '0;
      first_flag_q   <= 1'b1;
      out_step_err_q <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      prev_gray_q    <= prev_gray_d;
      first_flag_q   <= first_flag_d;
      out_step_err_q <= out_step_err_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign out_step_err = out_step_err_q;
  assign err_cnt      = err_cnt_q;
`else
  assign out_step_err = 1'b0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_gray_bin_decoder.sv
// Self-checking bench for gray_bin_decoder. A behavioural model (Gray table
// inversion, bit counting, plain integer error count) predicts every output.
// A second instance with a 2-bit error counter shares the stimulus so that
// counter saturation can be observed.
`timescale 1ns/1ps
module tb_gray_bin_decoder;

  localparam int W = 3;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_gray = '0;
  logic         in_ready, out_valid, out_step_err;
  logic [W-1:0] out_bin;
  logic [7:0]   err_cnt;
  logic         sat_in_ready, sat_out_valid, sat_step_err;
  logic [W-1:0] sat_out_bin;
  logic [1:0]   sat_err_cnt;

  int total = 0;
  int bad = 0;

  // reference model state
  bit m_valid;
  int m_bin;
  bit m_err;
  int m_errors;
  int m_prev;
  bit m_first;
  bit obs_ready;
  bit exp_ready;

  gray_bin_decoder #(.WIDTH(W), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_step_err(out_step_err), .err_cnt(err_cnt)
  );

  gray_bin_decoder #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_gray(in_gray), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_bin(sat_out_bin), .out_step_err(sat_step_err), .err_cnt(sat_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Binary value whose reflected Gray code equals g, found by table search.
  function automatic int ref_bin(input int g);
    for (int b = 0; b < (1 << W); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_bin    = 0;
    m_err    = 1'b0;
    m_errors = 0;
    m_prev   = 0;
    m_first  = 1'b1;
  endtask

  // Drives one cycle starting just after a falling edge, predicts the
  // handshake, advances the model at the rising edge and returns at the
  // next falling edge where outputs are stable.
  task automatic drive_cycle(input bit v, input int g, input bit r);
    in_valid  = v;
    in_gray   = W'(g);
    out_ready = r;
    #1;
    obs_ready = in_ready;
    exp_ready = !m_valid || r;
    @(posedge clk);
    if (v && exp_ready) begin
      m_err   = STEP_ON && !m_first && ($countones(g ^ m_prev) >= 2);
      m_bin   = ref_bin(g);
      m_valid = 1'b1;
      m_prev  = g;
      m_first = 1'b0;
      if (m_err) m_errors++;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    total++; if (out_bin !== '0) begin bad++; $display("[TB] FAIL reset_bin: got %0d expected 0", out_bin); end
    total++; if (out_step_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_step_err: got %0b expected 0", out_step_err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode_sweep();
    int seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, seq[i], 1'b1);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL sweep_ready[%0d]: got %0b expected 1", i, obs_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL sweep_valid[%0d]: got %0b expected 1", i, out_valid); end
      total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL sweep_bin[%0d]: got %0d expected %0d", i, out_bin, m_bin); end
      total++; if (out_step_err !== m_err) begin bad++; $display("[TB] FAIL sweep_step_err[%0d]: got %0b expected %0b", i, out_step_err, m_err); end
    end
    total++; if (err_cnt !== 8'(sat(m_errors, 255))) begin bad++; $display("[TB] FAIL sweep_err_cnt: got %0d expected %0d", err_cnt, m_errors); end
  endtask

  task automatic test_wrap_repeat();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 0, 1'b1);
      total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL wrap_bin[%0d]: got %0d expected %0d", i, out_bin, m_bin); end
      total++; if (out_step_err !== m_err) begin bad++; $display("[TB] FAIL wrap_step_err[%0d]: got %0b expected %0b", i, out_step_err, m_err); end
    end
  endtask

  task automatic test_illegal_jump();
    int seq [3] = '{0, 3, 2};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, seq[i], 1'b1);
      total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL jump_bin[%0d]: got %0d expected %0d", i, out_bin, m_bin); end
      total++; if (out_step_err !== m_err) begin bad++; $display("[TB] FAIL jump_step_err[%0d]: got %0b expected %0b", i, out_step_err, m_err); end
      total++; if (err_cnt !== 8'(sat(m_errors, 255))) begin bad++; $display("[TB] FAIL jump_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, m_errors); end
    end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b0, 0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain_valid: got %0b expected 0", out_valid); end
    drive_cycle(1'b1, 6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 7, 1'b0);
      total++; if (obs_ready !== exp_ready) begin bad++; $display("[TB] FAIL bp_ready[%0d]: got %0b expected %0b", i, obs_ready, exp_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d]: got %0b expected 1", i, out_valid); end
      total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL bp_hold_bin[%0d]: got %0d expected %0d", i, out_bin, m_bin); end
    end
    drive_cycle(1'b1, 7, 1'b1);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %0b expected 1", obs_ready); end
    total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL bp_next_bin: got %0d expected %0d", out_bin, m_bin); end
    drive_cycle(1'b0, 0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int seq [6] = '{0, 3, 0, 3, 0, 3};
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (seq[i]) drive_cycle(1'b1, seq[i], 1'b1);
    drive_cycle(1'b0, 0, 1'b0);
    total++; if (err_cnt !== 8'(sat(m_errors, 255))) begin bad++; $display("[TB] FAIL mid_pre_err_cnt: got %0d expected %0d", err_cnt, m_errors); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid: got %0b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_valid: got %0b expected 0", out_valid); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_async_err_cnt: got %0d expected 0", err_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_async_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 7, 1'b1);
    total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL mid_first_bin: got %0d expected %0d", out_bin, m_bin); end
    total++; if (out_step_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_first_step_err: got %0b expected 0", out_step_err); end
  endtask

  task automatic test_saturation();
    int seq [7] = '{0, 3, 0, 3, 0, 3, 0};
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (seq[i]) begin
      drive_cycle(1'b1, seq[i], 1'b1);
      total++; if (sat_err_cnt !== 2'(sat(m_errors, 3))) begin bad++; $display("[TB] FAIL sat_err_cnt[%0d]: got %0d expected %0d", i, sat_err_cnt, sat(m_errors, 3)); end
      total++; if (err_cnt !== 8'(sat(m_errors, 255))) begin bad++; $display("[TB] FAIL sat_wide_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, m_errors); end
      total++; if (sat_out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL sat_bin[%0d]: got %0d expected %0d", i, sat_out_bin, m_bin); end
    end
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, (1 << W) - 1));
      else g = m_prev ^ (1 << $urandom_range(0, W - 1));
      drive_cycle(1'($urandom_range(0, 1)), g, ($urandom_range(0, 3) != 0));
      total++; if (obs_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready[%0d]: got %0b expected %0b", i, obs_ready, exp_ready); end
      total++; if (out_valid !== m_valid) begin bad++; $display("[TB] FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (out_bin !== W'(m_bin)) begin bad++; $display("[TB] FAIL rnd_bin[%0d]: got %0d expected %0d", i, out_bin, m_bin); end
        total++; if (out_step_err !== m_err) begin bad++; $display("[TB] FAIL rnd_step_err[%0d]: got %0b expected %0b", i, out_step_err, m_err); end
      end
      total++; if (err_cnt !== 8'(sat(m_errors, 255))) begin bad++; $display("[TB] FAIL rnd_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, sat(m_errors, 255)); end
      total++; if (sat_err_cnt !== 2'(sat(m_errors, 3))) begin bad++; $display("[TB] FAIL rnd_sat_cnt[%0d]: got %0d expected %0d", i, sat_err_cnt, sat(m_errors, 3)); end
    end
  endtask

  initial begin
    $display("[TB] gray_bin_decoder bench start, step check %0s", STEP_ON ? "on" : "off");
    test_reset();
    test_decode_sweep();
    test_wrap_repeat();
    test_illegal_jump();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
